// File: rtl/adder_array_checker_if.sv
// Sample/response bus between the adder_array self-test driver and its checker.
// The master side drives run control plus the observed adder_array vector; the
// slave side (the checker) returns run status and the scoring results.
interface adder_array_checker_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
);

   // Run control
   logic             start;
   logic [CNT_W-1:0] num_vectors;

   // Observed adder_array vector: stimulus and response
   logic             sample_valid;
   logic [2:0]       cmd;
   logic [WIDTH-1:0] ain0;
   logic [WIDTH-1:0] ain1;
   logic [WIDTH-1:0] ain2;
   logic [WIDTH-1:0] ain3;
   logic [WIDTH-1:0] bin0;
   logic [WIDTH-1:0] bin1;
   logic [WIDTH-1:0] bin2;
   logic [WIDTH-1:0] bin3;
   logic [WIDTH-1:0] dout0;
   logic [WIDTH-1:0] dout1;
   logic [WIDTH-1:0] dout2;
   logic [WIDTH-1:0] dout3;
   logic [3:0]       overflow;

   // Run status and scoring results
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_count;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] first_fail_idx;
   logic [3:0]       first_fail_lane;

   modport master (
      output start,
      output num_vectors,
      output sample_valid,
      output cmd,
      output ain0,
      output ain1,
      output ain2,
      output ain3,
      output bin0,
      output bin1,
      output bin2,
      output bin3,
      output dout0,
      output dout1,
      output dout2,
      output dout3,
      output overflow,
      input  busy,
      input  done,
      input  pass,
      input  vec_count,
      input  err_count,
      input  first_fail_idx,
      input  first_fail_lane
   );

   modport slave (
      input  start,
      input  num_vectors,
      input  sample_valid,
      input  cmd,
      input  ain0,
      input  ain1,
      input  ain2,
      input  ain3,
      input  bin0,
      input  bin1,
      input  bin2,
      input  bin3,
      input  dout0,
      input  dout1,
      input  dout2,
      input  dout3,
      input  overflow,
      output busy,
      output done,
      output pass,
      output vec_count,
      output err_count,
      output first_fail_idx,
      output first_fail_lane
   );

endinterface

// File: rtl/adder_array_checker.sv
// Response checker for the 4-lane adder_array. Recomputes the expected lane
// results for each sampled vector, and scores a run of num_vectors vectors:
// vector count, saturating error count and sticky first-failure capture.
// Two-stage pipeline: S1 holds the accepted vector, S2 holds its lane mismatch mask.
module adder_array_checker #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic                  clk,
   input logic                  rst,
   adder_array_checker_if.slave bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   // FSM and run scoring state
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] target_q;
   logic [CNT_W-1:0] vec_count_q;
   logic [CNT_W-1:0] err_count_q;
   logic [CNT_W-1:0] first_fail_idx_q;
   logic [3:0]       first_fail_lane_q;

   // S1: registered copy of the accepted vector
   logic                  s1_valid_q;
   logic [2:0]            s1_cmd_q;
   logic [3:0][WIDTH-1:0] s1_ain_q;
   logic [3:0][WIDTH-1:0] s1_bin_q;
   logic [3:0][WIDTH-1:0] s1_dout_q;
   logic [3:0]            s1_ov_q;
   logic [CNT_W-1:0]      s1_idx_q;

   // S2: lane mismatch mask of the S1 vector
   logic             s2_valid_q;
   logic [3:0]       s2_mask_q;
   logic [CNT_W-1:0] s2_idx_q;

   logic       start_ok;
   logic       accept;
   logic       s2_fail;
   logic [3:0] lane_mask;

   // start is only honoured outside a run; a zero-length run goes straight to DONE
   assign start_ok = bus.start && (state_q != StRun);
   assign accept   = (state_q == StRun) && bus.sample_valid && (vec_count_q < target_q);
   assign s2_fail  = s2_valid_q && (s2_mask_q != 4'b0000);

   // Next-state logic for the run FSM
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = (bus.num_vectors == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            // S2 retires on this same edge, so DONE and the final score land together
            if ((vec_count_q == target_q) && !s1_valid_q) begin
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Golden model of the adder lanes compared against the S1 response
   always_comb begin
      logic             lane_en;
      logic [WIDTH:0]   exp_sum;
      lane_mask = 4'b0000;
      lane_en   = 1'b0;
      exp_sum   = '0;
      for (int k = 0; k < 4; k++) begin
         lane_en = (s1_cmd_q == 3'(k)) || (s1_cmd_q == 3'd4);
         exp_sum = lane_en ? ({1'b0, s1_ain_q[k]} + {1'b0, s1_bin_q[k]}) : '0;
         lane_mask[k] = (s1_dout_q[k] != exp_sum[WIDTH-1:0]) || (s1_ov_q[k] != exp_sum[WIDTH]);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Run counters, pipeline valids and first-failure capture
   always_ff @(posedge clk) begin
      if (rst) begin
         target_q          <= '0;
         vec_count_q       <= '0;
         err_count_q       <= '0;
         first_fail_idx_q  <= '0;
         first_fail_lane_q <= 4'b0000;
         s1_valid_q        <= 1'b0;
         s2_valid_q        <= 1'b0;
         s2_mask_q         <= 4'b0000;
         s2_idx_q          <= '0;
      end else if (start_ok) begin
         target_q          <= bus.num_vectors;
         vec_count_q       <= '0;
         err_count_q       <= '0;
         first_fail_idx_q  <= '0;
         first_fail_lane_q <= 4'b0000;
         s1_valid_q        <= 1'b0;
         s2_valid_q        <= 1'b0;
         s2_mask_q         <= 4'b0000;
         s2_idx_q          <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            vec_count_q <= vec_count_q + CntOne;
         end
         s2_valid_q <= s1_valid_q;
         s2_mask_q  <= lane_mask;
         s2_idx_q   <= s1_idx_q;
         if (s2_fail) begin
            // Only the first failing vector of a run is captured
            if (err_count_q == '0) begin
               first_fail_idx_q  <= s2_idx_q;
               first_fail_lane_q <= s2_mask_q;
            end
            if (err_count_q != CntMax) begin
               err_count_q <= err_count_q + CntOne;
            end
         end
      end
   end

   // S1 vector payload; qualified by s1_valid_q so it needs no reset
   always_ff @(posedge clk) begin
      if (accept) begin
         s1_cmd_q  <= bus.cmd;
         s1_ain_q  <= {bus.ain3, bus.ain2, bus.ain1, bus.ain0};
         s1_bin_q  <= {bus.bin3, bus.bin2, bus.bin1, bus.bin0};
         s1_dout_q <= {bus.dout3, bus.dout2, bus.dout1, bus.dout0};
         s1_ov_q   <= bus.overflow;
         s1_idx_q  <= vec_count_q;
      end
   end

   assign bus.busy            = (state_q == StRun);
   assign bus.done            = (state_q == StDone);
   assign bus.pass            = (state_q == StDone) && (err_count_q == '0);
   assign bus.vec_count       = vec_count_q;
   assign bus.err_count       = err_count_q;
   assign bus.first_fail_idx  = first_fail_idx_q;
   assign bus.first_fail_lane = first_fail_lane_q;

endmodule
